// File: rtl/dram_rd_sched_if.sv
// ---------------------------------------------------------------------------
// dram_rd_sched_if
// Bundles the configuration/status registers and the reader-engine bus of the
// DRAM read scheduler.
//   cfg_*          software request (start pulse, abort, base, length, shift,
//                  iterations)
//   rd_enable      per-reader enable level
//   rd_start_addr  per-reader start line, reader i at [32*i +: 32]
//   rd_read_len    per-reader line count, reader i at [32*i +: 32]
//   rd_done        per-reader done level
//   busy/done/err_timeout/err_aborted/cycle_count/iter_count  status
// Modports: slave = scheduler, master = config block plus reader engines.
// ---------------------------------------------------------------------------
interface dram_rd_sched_if #(
  parameter int NUM_RD = 4,
  parameter int CNT_W  = 40
);
  localparam int SW = $clog2(NUM_RD) + 1;

  logic                 cfg_start;
  logic                 cfg_abort;
  logic [31:0]          cfg_base_line;
  logic [31:0]          cfg_total_len;
  logic [SW-1:0]        cfg_rd_shift;
  logic [15:0]          cfg_iters;
  logic [NUM_RD-1:0]    rd_enable;
  logic [32*NUM_RD-1:0] rd_start_addr;
  logic [32*NUM_RD-1:0] rd_read_len;
  logic [NUM_RD-1:0]    rd_done;
  logic                 busy;
  logic                 done;
  logic                 err_timeout;
  logic                 err_aborted;
  logic [CNT_W-1:0]     cycle_count;
  logic [15:0]          iter_count;

  modport slave (
    input  cfg_start, cfg_abort, cfg_base_line, cfg_total_len, cfg_rd_shift,
           cfg_iters, rd_done,
    output rd_enable, rd_start_addr, rd_read_len, busy, done, err_timeout,
           err_aborted, cycle_count, iter_count
  );

  modport master (
    output cfg_start, cfg_abort, cfg_base_line, cfg_total_len, cfg_rd_shift,
           cfg_iters, rd_done,
    input  rd_enable, rd_start_addr, rd_read_len, busy, done, err_timeout,
           err_aborted, cycle_count, iter_count
  );
endinterface

// File: rtl/dram_rd_sched.sv
// ---------------------------------------------------------------------------
// dram_rd_sched
// Splits one read request into contiguous per-reader slices, launches all
// readers together, waits for every active reader, drains the done handshake
// and repeats for the programmed iteration count. Run cycles are accumulated
// (saturating) for bandwidth calculation.
// Ports:
//   clk    core clock
//   rst_n  async active-low reset; drops rd_enable immediately
//   bus    dram_rd_sched_if.slave (config, reader bus, status)
// ---------------------------------------------------------------------------
module dram_rd_sched #(
  parameter int NUM_RD  = 4,
  parameter int CNT_W   = 40,
  parameter int TIMEOUT = 2**24
) (
  input  logic           clk,
  input  logic           rst_n,
  dram_rd_sched_if.slave bus
);
  localparam int LOG2 = $clog2(NUM_RD);
  localparam int SW   = LOG2 + 1;
  localparam int TW   = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, FINISH} state_t;

  state_t            state, state_n;

  logic [31:0]       base_q, total_q;
  logic [SW-1:0]     shift_q;
  logic [15:0]       iters_q;
  logic [NUM_RD-1:0] mask_q, mask_n, seen_q, rd_enable_q;
  logic [31:0]       start_q [NUM_RD];
  logic [31:0]       len_q   [NUM_RD];
  logic [31:0]       start_n [NUM_RD];
  logic [31:0]       len_n   [NUM_RD];
  logic [TW-1:0]     run_cnt;
  logic [CNT_W-1:0]  cycle_q;
  logic [15:0]       iter_q;
  logic              err_to_q, err_ab_q;
  logic              all_seen, run_abort, run_ok, run_to;
  int                n_act;
  logic [31:0]       chunk;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: every combinational output gets a default first, otherwise a path
  // that leaves it unassigned infers a latch.
  always_comb begin
    state_n   = state;
    run_abort = 1'b0;
    run_ok    = 1'b0;
    run_to    = 1'b0;
    // A reader is finished if seen earlier, done this cycle, or masked off.
    all_seen  = &(seen_q | bus.rd_done | ~mask_q);
    unique case (state)
      IDLE:   if (bus.cfg_start) state_n = SETUP;
      SETUP:  state_n = bus.cfg_abort ? DRAIN : RUN;
      RUN: begin
        // Abort beats completion; completion beats timeout on the same cycle.
        if (bus.cfg_abort)                     run_abort = 1'b1;
        else if (all_seen)                     run_ok    = 1'b1;
        else if (run_cnt == TW'(TIMEOUT - 1))  run_to    = 1'b1;
        if (run_abort || run_ok || run_to) state_n = DRAIN;
      end
      DRAIN: begin
        if (bus.rd_done == '0) begin
          if (err_to_q || err_ab_q || bus.cfg_abort) state_n = FINISH;
          // iter_q already counts the iteration that just finished.
          else if (iter_q < iters_q)                 state_n = SETUP;
          else                                       state_n = FINISH;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Slice computation from the latched request; the last active reader
  // absorbs the remainder. Sums wrap modulo 2^32.
  always_comb begin
    n_act = 1 << shift_q;
    chunk = total_q >> shift_q;
    for (int i = 0; i < NUM_RD; i++) begin
      start_n[i] = '0;
      len_n[i]   = '0;
      mask_n[i]  = 1'b0;
      if (i < n_act) begin
        start_n[i] = base_q + chunk * 32'(i);
        len_n[i]   = (i == n_act - 1) ? total_q - chunk * 32'(i) : chunk;
        mask_n[i]  = (len_n[i] != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      total_q     <= '0;
      shift_q     <= '0;
      iters_q     <= '0;
      mask_q      <= '0;
      seen_q      <= '0;
      rd_enable_q <= '0;
      // NOTE: the slice arrays drive output ports, so they are reset like
      // any other register rather than left as uninitialised storage.
      start_q     <= '{default: '0};
      len_q       <= '{default: '0};
      run_cnt     <= '0;
      cycle_q     <= '0;
      iter_q      <= '0;
      err_to_q    <= 1'b0;
      err_ab_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cfg_start) begin
            base_q   <= bus.cfg_base_line;
            total_q  <= bus.cfg_total_len;
            shift_q  <= (bus.cfg_rd_shift > SW'(LOG2)) ? SW'(LOG2) : bus.cfg_rd_shift;
            iters_q  <= (bus.cfg_iters == '0) ? 16'd1 : bus.cfg_iters;
            cycle_q  <= '0;
            iter_q   <= '0;
            err_to_q <= 1'b0;
            err_ab_q <= 1'b0;
          end
        end
        SETUP: begin
          start_q <= start_n;
          len_q   <= len_n;
          mask_q  <= mask_n;
          seen_q  <= '0;
          run_cnt <= '0;
          if (bus.cfg_abort) err_ab_q <= 1'b1;
        end
        RUN: begin
          seen_q  <= seen_q | bus.rd_done;
          run_cnt <= run_cnt + TW'(1);
          if (cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
          if (run_ok)        iter_q   <= iter_q + 16'd1;
          if (run_abort)     err_ab_q <= 1'b1;
          if (run_to)        err_to_q <= 1'b1;
        end
        DRAIN: if (bus.cfg_abort) err_ab_q <= 1'b1;
        default: ;
      endcase

      // Enable is high exactly for the RUN cycles of each iteration.
      if (state == SETUP && state_n == RUN) rd_enable_q <= mask_n;
      else if (state_n != RUN)              rd_enable_q <= '0;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_pack
    assign bus.rd_start_addr[32*g +: 32] = start_q[g];
    assign bus.rd_read_len[32*g +: 32]   = len_q[g];
  end

  assign bus.rd_enable   = rd_enable_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == FINISH);
  assign bus.err_timeout = err_to_q;
  assign bus.err_aborted = err_ab_q;
  assign bus.cycle_count = cycle_q;
  assign bus.iter_count  = iter_q;
endmodule

// File: tb/tb_dram_rd_sched.sv
// ---------------------------------------------------------------------------
// tb_dram_rd_sched
// Drives dram_rd_sched through directed and randomized requests. Reader
// engines are modelled with a per-reader done latency; expected slices, run
// cycles and status are derived from the request with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_dram_rd_sched;
  localparam int NUM_RD  = 4;
  localparam int CNT_W   = 40;
  localparam int TIMEOUT = 64;
  localparam int LOG2    = $clog2(NUM_RD);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_rd_sched_if #(.NUM_RD(NUM_RD), .CNT_W(CNT_W)) bus ();

  dram_rd_sched #(.NUM_RD(NUM_RD), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reader model: done rises once enable has been high for lat cycles
  // (visible in enable cycle lat+1); lat==0 never finishes. Done falls
  // drain_lat+1 cycles after enable drops.
  int                lat     [NUM_RD];
  int                en_cyc  [NUM_RD];
  int                off_cyc [NUM_RD];
  int                drain_lat = 0;
  logic [NUM_RD-1:0] done_r     = '0;
  logic [NUM_RD-1:0] force_done = '0;

  // Expected results for the current request.
  logic [31:0]       exp_start [NUM_RD];
  logic [31:0]       exp_len   [NUM_RD];
  logic [NUM_RD-1:0] exp_mask;
  longint            exp_cycles;
  int                exp_iter, exp_pulses;
  bit                exp_to, exp_ab;

  // Observations.
  int                en_pulses = 0;
  int                done_pulses = 0;
  logic [NUM_RD-1:0] ever_en = '0;
  logic [NUM_RD-1:0] prev_en = '0;
  bit                slice_bad = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.rd_enable[i]) begin
        en_cyc[i]  = en_cyc[i] + 1;
        off_cyc[i] = 0;
        if (lat[i] != 0 && en_cyc[i] > lat[i]) done_r[i] = 1'b1;
      end else begin
        en_cyc[i] = 0;
        if (done_r[i]) begin
          off_cyc[i] = off_cyc[i] + 1;
          if (off_cyc[i] > drain_lat) done_r[i] = 1'b0;
        end
      end
    end
    bus.rd_done = done_r | force_done;
  end

  always @(negedge clk) begin
    if (bus.rd_enable != '0 && prev_en == '0) en_pulses++;
    prev_en = bus.rd_enable;
    ever_en = ever_en | bus.rd_enable;
    if (bus.done) done_pulses++;
    if (bus.rd_enable != '0) begin
      for (int i = 0; i < NUM_RD; i++)
        if (bus.rd_start_addr[32*i +: 32] != exp_start[i] ||
            bus.rd_read_len[32*i +: 32] != exp_len[i]) slice_bad = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lats(input int a, input int b, input int c, input int d);
    lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
  endtask

  // Reference model: slices by division, run length as the slowest active
  // reader, timeout if that exceeds the per-iteration budget.
  task automatic model(input logic [31:0] base, input logic [31:0] total,
                       input int shift, input int iters);
    int n, sh, run_len, c, it;
    logic [31:0] chunk;
    sh      = (shift > LOG2) ? LOG2 : shift;
    n       = 2 ** sh;
    chunk   = total / 32'(n);
    exp_mask = '0;
    run_len = 1;
    for (int i = 0; i < NUM_RD; i++) begin
      exp_start[i] = '0;
      exp_len[i]   = '0;
      if (i < n) begin
        exp_start[i] = base + chunk * i;
        exp_len[i]   = (i == n - 1) ? total - chunk * (n - 1) : chunk;
        if (exp_len[i] != 0) begin
          exp_mask[i] = 1'b1;
          c = force_done[i] ? 1 : ((lat[i] == 0) ? TIMEOUT + 1 : lat[i] + 1);
          if (c > run_len) run_len = c;
        end
      end
    end
    it     = (iters == 0) ? 1 : iters;
    exp_ab = 0;
    if (run_len > TIMEOUT) begin
      exp_to = 1; exp_iter = 0; exp_cycles = TIMEOUT; exp_pulses = 1;
    end else begin
      exp_to = 0; exp_iter = it; exp_cycles = longint'(it) * run_len;
      exp_pulses = (exp_mask != '0) ? it : 0;
    end
  endtask

  task automatic start_test(input logic [31:0] base, input logic [31:0] total,
                            input int shift, input int iters);
    model(base, total, shift, iters);
    en_pulses = 0; done_pulses = 0; ever_en = '0; slice_bad = 0;
    bus.cfg_base_line = base;
    bus.cfg_total_len = total;
    bus.cfg_rd_shift  = 3'(shift);
    bus.cfg_iters     = 16'(iters);
    bus.cfg_start     = 1'b1;
    tick();
    bus.cfg_start     = 1'b0;
  endtask

  task automatic finish_checks(input string t);
    bit ok;
    ok = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (done_pulses != 0) begin ok = 1; break; end
    end
    check({t, " completed"}, 64'(ok), 64'd1);
    repeat (3) tick();
    check({t, " done_pulses"}, 64'(done_pulses), 64'd1);
    check({t, " busy"}, 64'(bus.busy), 64'd0);
    check({t, " iter_count"}, 64'(bus.iter_count), 64'(exp_iter));
    check({t, " cycle_count"}, 64'(bus.cycle_count), 64'(exp_cycles));
    check({t, " err_timeout"}, 64'(bus.err_timeout), 64'(exp_to));
    check({t, " err_aborted"}, 64'(bus.err_aborted), 64'(exp_ab));
    check({t, " enable_pulses"}, 64'(en_pulses), 64'(exp_pulses));
    check({t, " enabled_set"}, 64'(ever_en), 64'(exp_mask));
    check({t, " slice_while_enabled"}, 64'(slice_bad), 64'd0);
    for (int i = 0; i < NUM_RD; i++) begin
      check($sformatf("%s start[%0d]", t, i), 64'(bus.rd_start_addr[32*i +: 32]), 64'(exp_start[i]));
      check($sformatf("%s len[%0d]", t, i), 64'(bus.rd_read_len[32*i +: 32]), 64'(exp_len[i]));
    end
  endtask

  initial begin
    bit ok;
    bus.cfg_start = 0; bus.cfg_abort = 0; bus.cfg_base_line = 0;
    bus.cfg_total_len = 0; bus.cfg_rd_shift = 0; bus.cfg_iters = 0;
    for (int i = 0; i < NUM_RD; i++) begin lat[i] = 1; en_cyc[i] = 0; off_cyc[i] = 0; end

    // Reset state.
    repeat (3) tick();
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset rd_enable", 64'(bus.rd_enable), 64'd0);
    check("reset cycle_count", 64'(bus.cycle_count), 64'd0);
    check("reset iter_count", 64'(bus.iter_count), 64'd0);
    check("reset errs", 64'({bus.err_timeout, bus.err_aborted}), 64'd0);
    check("reset start_addr", 64'(bus.rd_start_addr[63:0]), 64'd0);
    rst_n = 1'b1;
    tick();

    // Even four-way split.
    drain_lat = 2;
    set_lats($urandom_range(3, 20), $urandom_range(3, 20), $urandom_range(3, 20), $urandom_range(3, 20));
    start_test(32'h100, 32'd1000, 2, 1);
    finish_checks("even_split");

    // Remainder absorbed by the last reader.
    set_lats(4, 9, 6, 12);
    start_test(32'h2000, 32'd1003, 2, 1);
    finish_checks("remainder");

    // Tiny request: chunk is zero, only the last reader carries lines.
    start_test(32'h40, 32'd2, 2, 1);
    finish_checks("tiny");

    // Three iterations, readers done in enable cycle 11.
    drain_lat = 3;
    set_lats(10, 10, 10, 10);
    start_test(32'h0, 32'd4096, 2, 3);
    finish_checks("iters3");

    // Reader 2 never finishes: timeout.
    set_lats(5, 8, 0, 7);
    start_test(32'h500, 32'd1000, 2, 2);
    finish_checks("timeout");

    // Slowest reader finishes exactly on the last allowed cycle.
    set_lats(63, 2, 2, 2);
    start_test(32'h700, 32'd400, 2, 1);
    finish_checks("edge_ok");

    // One cycle too slow.
    set_lats(64, 2, 2, 2);
    start_test(32'h700, 32'd400, 2, 1);
    finish_checks("edge_timeout");

    // Abort in iteration 2 coincident with the last done; stray start while busy.
    drain_lat = 1;
    set_lats(10, 10, 10, 10);
    start_test(32'h1234, 32'd800, 2, 3);
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      if (en_pulses == 1) begin ok = 1; break; end
      tick();
    end
    check("abort iter1 reached", 64'(ok), 64'd1);
    bus.cfg_base_line = 32'hDEAD_0000;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    check("abort stray start busy", 64'(bus.busy), 64'd1);
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      if (en_pulses == 2 && en_cyc[0] == 10) begin ok = 1; break; end
      tick();
    end
    check("abort iter2 reached", 64'(ok), 64'd1);
    bus.cfg_abort = 1'b1;
    tick();
    bus.cfg_abort = 1'b0;
    exp_ab = 1; exp_iter = 1; exp_cycles = 22; exp_pulses = 2;
    finish_checks("abort");

    // Address wrap across 2^32.
    set_lats(3, 5, 1, 1);
    start_test(32'hFFFF_FFF0, 32'd64, 1, 1);
    finish_checks("wrap");

    // Oversized shift clamps to all readers; iters 0 runs once.
    set_lats(2, 3, 4, 5);
    start_test(32'h10, 32'd100, 3, 0);
    finish_checks("clamp_iters0");

    // Empty request: nothing enabled, one RUN cycle.
    start_test(32'h10, 32'd0, 2, 2);
    finish_checks("empty");

    // Randomized requests.
    for (int r = 0; r < 6; r++) begin
      drain_lat = $urandom_range(0, 4);
      set_lats($urandom_range(1, 25), $urandom_range(1, 25), $urandom_range(1, 25), $urandom_range(1, 25));
      start_test($urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom_range(0, 3000)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      finish_checks($sformatf("rand%0d", r));
    end

    // A reader stuck with done high holds DRAIN without a second timeout.
    drain_lat = 0;
    set_lats(5, 6, 7, 5);
    force_done = 4'b1000;
    start_test(32'h3000, 32'd1000, 2, 1);
    repeat (150) tick();
    check("stuck busy", 64'(bus.busy), 64'd1);
    check("stuck no done", 64'(done_pulses), 64'd0);
    check("stuck no timeout", 64'(bus.err_timeout), 64'd0);
    force_done = '0;
    finish_checks("stuck");

    // Reset mid-RUN clears everything without waiting for a clock edge.
    set_lats(40, 40, 40, 40);
    start_test(32'h9000, 32'd1000, 2, 1);
    repeat (10) tick();
    check("rst pre enable", 64'(bus.rd_enable), 64'(exp_mask));
    rst_n = 1'b0;
    #1;
    check("rst rd_enable", 64'(bus.rd_enable), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst cycle_count", 64'(bus.cycle_count), 64'd0);
    check("rst iter_count", 64'(bus.iter_count), 64'd0);
    check("rst start_addr", 64'(bus.rd_start_addr[63:0]), 64'd0);
    check("rst read_len", 64'(bus.rd_read_len[63:0]), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Recovery after reset.
    set_lats(4, 4, 6, 3);
    start_test(32'h55, 32'd333, 1, 2);
    finish_checks("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
